// File: rtl/regbank_sb.sv
// Parametrised register bank: 2 combinational read ports, 1 write port, busy scoreboard
// and a one-entry-per-cycle soft-clear sequencer. Optional write-through forwarding: REGBANK_BYPASS_EN.
module regbank_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              We,
  input  logic [ADDR_W-1:0] Addr_Rd,
  input  logic [DATA_W-1:0] W_Data,
  input  logic [ADDR_W-1:0] Addr_Ra,
  input  logic [ADDR_W-1:0] Addr_Rb,
  output logic [DATA_W-1:0] Ra_out,
  output logic [DATA_W-1:0] Rb_out,
  input  logic              Iss_Valid,
  input  logic [ADDR_W-1:0] Iss_Addr,
  output logic              Ra_busy,
  output logic              Rb_busy,
  input  logic              Clr_Req,
  output logic              Clr_Busy,
  output logic              Ready,
  output logic              o_dbg_state
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_clr_busy;
  logic [DATA_W-1:0]   r_bank [DEPTH];
  logic [DEPTH-1:0]    r_busy;

  logic w_wr_ok;
  logic w_iss_ok;
  logic w_zero_a;
  logic w_zero_b;

  // Write/issue only land in IDLE and lose to a same-cycle clear request.
  assign w_wr_ok  = We && !r_clr_busy && !Clr_Req;
  assign w_iss_ok = Iss_Valid && !r_clr_busy && !Clr_Req && !(ZR && Iss_Addr == '0);
  assign w_zero_a = (ZR && Addr_Ra == '0) || r_clr_busy;
  assign w_zero_b = (ZR && Addr_Rb == '0) || r_clr_busy;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_clr_busy <= 1'b0;
      r_busy     <= '0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Clr_Req) begin
            r_state    <= S_CLEAR;
            r_idx      <= '0;
            r_clr_busy <= 1'b1;
            r_busy     <= '0;
          end else begin
            if (w_wr_ok && !(ZR && Addr_Rd == '0)) r_bank[Addr_Rd] <= W_Data;
            if (w_wr_ok) r_busy[Addr_Rd] <= 1'b0;
            // Issue is evaluated last so a new producer wins over write-back.
            if (w_iss_ok) r_busy[Iss_Addr] <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_bank[r_idx] <= '0;
          r_idx         <= r_idx + 1'b1;
          if (r_idx == ADDR_W'(DEPTH-1)) begin
            r_state    <= S_IDLE;
            r_clr_busy <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_clr_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGBANK_BYPASS_EN
  logic w_fwd_a;
  logic w_fwd_b;
  assign w_fwd_a = w_wr_ok && (Addr_Rd == Addr_Ra);
  assign w_fwd_b = w_wr_ok && (Addr_Rd == Addr_Rb);
  assign Ra_out  = w_zero_a ? '0 : (w_fwd_a ? W_Data : r_bank[Addr_Ra]);
  assign Rb_out  = w_zero_b ? '0 : (w_fwd_b ? W_Data : r_bank[Addr_Rb]);
  assign Ra_busy = r_busy[Addr_Ra] && !w_fwd_a;
  assign Rb_busy = r_busy[Addr_Rb] && !w_fwd_b;
`else
  assign Ra_out  = w_zero_a ? '0 : r_bank[Addr_Ra];
  assign Rb_out  = w_zero_b ? '0 : r_bank[Addr_Rb];
  assign Ra_busy = r_busy[Addr_Ra];
  assign Rb_busy = r_busy[Addr_Rb];
`endif

  assign Clr_Busy    = r_clr_busy;
  assign Ready       = ~r_clr_busy;
  assign o_dbg_state = (r_state == S_CLEAR);

endmodule
